// File: rtl/alu_pkg.sv
// Shared ALU constants: sequencer state encodings and default serial subtract width.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Flag signals exist only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = alu_pkg::SUB_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_FLAGS_EN
    , input zero, neg, ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_FLAGS_EN
    , output zero, neg, ovf
`endif
  );
endinterface

// File: rtl/sub_1b.sv
// One-bit full subtractor: z = x - y - b_in, b_out = borrow out.
module sub_1b (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic z,
  output logic b_out
);
  assign z     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one sub_1b slice, LSB first, result held until taken.
// Optional zero/neg/ovf flags when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  bus
);
  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             z;
  logic             b_out;
  logic             accept;
  logic             last_bit;
  logic             in_ready_c;
  logic             out_valid_c;

  sub_1b u_slice (
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .b_in  (borrow_q),
    .z     (z),
    .b_out (b_out)
  );

  assign accept   = (state_q == ST_IDLE) && bus.in_valid;
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_bit)      state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_c  = 1'b1;
      ST_DONE: out_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at res_sh[0].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_sh     <= bus.a;
      b_sh     <= bus.b;
      borrow_q <= bus.bin;
      cnt_q    <= '0;
    end else if (state_q == ST_RUN) begin
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      res_sh   <= {z, res_sh[WIDTH-1:1]};
      borrow_q <= b_out;
      if (!last_bit) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = res_sh;
  assign bus.bout      = borrow_q;

`ifdef SERIAL_SUB_FLAGS_EN
  logic             a_msb_q;
  logic             b_msb_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
  logic [WIDTH-1:0] diff_final;

  assign diff_final = {z, res_sh[WIDTH-1:1]};

  // Flags are computed from the completed result on the final bit cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
    end else if (last_bit) begin
      zero_q  <= (diff_final == '0);
      neg_q   <= diff_final[WIDTH-1];
      ovf_q   <= (a_msb_q != b_msb_q) && (diff_final[WIDTH-1] != a_msb_q);
    end
  end

  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    step(); step();
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.diff !== 8'h00) $display("FAIL reset_diff got %h want 00", bus.diff); else passed++;
    checks++; if (bus.bout !== 1'b0) $display("FAIL reset_bout got %b want 0", bus.bout); else passed++;
`ifdef SERIAL_SUB_FLAGS_EN
    checks++; if ({bus.zero, bus.neg, bus.ovf} !== 3'b000) $display("FAIL reset_flags got %b want 000", {bus.zero, bus.neg, bus.ovf}); else passed++;
`endif
    rst_n = 1'b1;
    step();
  endtask

  // Accept one op, scramble inputs, check latency and result, then take it.
  task automatic do_op(input string name, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic ez, input logic en, input logic eo);
    int cyc;
    bus.a = av; bus.b = bv; bus.bin = bi; bus.in_valid = 1'b1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready got %b want 1", name, bus.in_ready); else passed++;
    step();
    bus.in_valid = 1'b0; bus.a = ~av; bus.b = 8'h5A; bus.bin = ~bi;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    checks++; if (cyc != WIDTH) $display("FAIL %s latency got %0d want %0d", name, cyc, WIDTH); else passed++;
    checks++; if (bus.diff !== ed) $display("FAIL %s diff got %h want %h", name, bus.diff, ed); else passed++;
    checks++; if (bus.bout !== eb) $display("FAIL %s bout got %b want %b", name, bus.bout, eb); else passed++;
`ifdef SERIAL_SUB_FLAGS_EN
    checks++; if ({bus.zero, bus.neg, bus.ovf} !== {ez, en, eo})
      $display("FAIL %s flags(z,n,o) got %b want %b", name, {bus.zero, bus.neg, bus.ovf}, {ez, en, eo}); else passed++;
`else
    if (ez === 1'bx || en === 1'bx || eo === 1'bx) $display("note: unknown flag expectation in %s", name);
`endif
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL %s after_take got %b want 10", name, {bus.in_ready, bus.out_valid}); else passed++;
  endtask

  task automatic test_arith();
    do_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("sub_ff_00_b", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("sub_00_ff", 8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flags();
    do_op("flags_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("flags_42_42", 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    int cyc;
    bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    checks++; if (cyc != WIDTH) $display("FAIL hold_latency got %0d want %0d", cyc, WIDTH); else passed++;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 2); bus.a = 8'h55; bus.b = 8'h11;
      step();
      checks++; if ({bus.out_valid, bus.in_ready, bus.diff} !== {2'b10, 8'h0F})
        $display("FAIL hold_cycle%0d got v=%b r=%b d=%h want v=1 r=0 d=0f", i, bus.out_valid, bus.in_ready, bus.diff); else passed++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10)
        $display("FAIL hold_ignored%0d got r=%b v=%b want r=1 v=0", i, bus.in_ready, bus.out_valid); else passed++;
      step();
    end
  endtask

  task automatic test_reset_mid_run();
    bus.a = 8'hAA; bus.b = 8'h11; bus.bin = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if ({bus.in_ready, bus.out_valid, bus.diff, bus.bout} !== {2'b10, 8'h00, 1'b0})
      $display("FAIL midrun_reset got r=%b v=%b d=%h bo=%b want r=1 v=0 d=00 bo=0", bus.in_ready, bus.out_valid, bus.diff, bus.bout); else passed++;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrun_no_pulse%0d got %b want 0", i, bus.out_valid); else passed++;
    end
    do_op("after_reset", 8'hAA, 8'h11, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_flags();
    test_hold();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
